bru_redirect_ctrl: RTL

//  Sequences branch-unit results from EX into front-end redirects.

---
 rtl/bru_redirect_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/bru_redirect_ctrl.sv
// bru_redirect_ctrl: turns EX branch results into predictor updates, pipe flushes and fetch redirects
//
// Optional feature macro: BRU_PERF_CNT_EN
//   When defined, two 32-bit performance counters are added as outputs.
//
// Ports:
//   clk, resetn                       core clock, asynchronous active-low reset
//   ex_br_valid/pc/bru_taken/target   resolved branch from EX
//   ex_pred_taken/target              prediction carried down the pipe
//   ex_br_ready                       always high once out of reset; EX is never stalled
//   exc_flush                         exception/ertn flush, overrides everything
//   fe_redir_valid/pc/ready           held redirect request to fetch
//   pipe_flush                        one-cycle kill of younger IF/ID instructions
//   bpu_upd_valid/pc/taken/target     one-cycle predictor update per accepted branch
//   perf_br_cnt, perf_mis_cnt         (BRU_PERF_CNT_EN only) accepted branch / mispredict counts
module bru_redirect_ctrl #(
    parameter int GRLEN     = 32,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_br_valid,
    input  logic [GRLEN-1:0] ex_br_pc,
    input  logic             ex_bru_taken,
    input  logic [GRLEN-1:0] ex_bru_target,
    input  logic             ex_pred_taken,
    input  logic [GRLEN-1:0] ex_pred_target,
    output logic             ex_br_ready,
    input  logic             exc_flush,
    output logic             fe_redir_valid,
    output logic [GRLEN-1:0] fe_redir_pc,
    input  logic             fe_redir_ready,
    output logic             pipe_flush,
    output logic             bpu_upd_valid,
    output logic [GRLEN-1:0] bpu_upd_pc,
    output logic             bpu_upd_taken,
    output logic [GRLEN-1:0] bpu_upd_target
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_br_cnt,
    output logic [31:0]      perf_mis_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_t;
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC);
    state_t     state;
    logic [3:0] cnt;
    logic       mis;
    logic       accept;
    // Target only matters when the branch is actually taken.
    assign mis    = (ex_bru_taken != ex_pred_taken) | (ex_bru_taken & (ex_bru_target != ex_pred_target));
    // Anything arriving outside IDLE is wrong-path and silently dropped.
    assign accept = (state == IDLE) & ex_br_valid & ~exc_flush;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            ex_br_ready    <= 1'b0;
            fe_redir_valid <= 1'b0;
            fe_redir_pc    <= '0;
            pipe_flush     <= 1'b0;
            bpu_upd_valid  <= 1'b0;
            bpu_upd_pc     <= '0;
            bpu_upd_taken  <= 1'b0;
            bpu_upd_target <= '0;
        end else begin
            ex_br_ready   <= 1'b1;
            bpu_upd_valid <= accept;
            pipe_flush    <= accept & mis;
            if (accept) begin
                bpu_upd_pc     <= ex_br_pc;
                bpu_upd_taken  <= ex_bru_taken;
                bpu_upd_target <= ex_bru_target;
            end
            if (exc_flush) begin
                state          <= IDLE;
                cnt            <= '0;
                fe_redir_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept & mis) begin
                        fe_redir_valid <= 1'b1;
                        fe_redir_pc    <= ex_bru_target;
                        state          <= REDIR;
                    end
                    REDIR: if (fe_redir_ready) begin
                        fe_redir_valid <= 1'b0;
                        cnt            <= DRAIN_INIT;
                        state          <= (DRAIN_CYC == 0) ? IDLE : DRAIN;
                    end
                    DRAIN: begin
                        cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_br_cnt  <= '0;
            perf_mis_cnt <= '0;
        end else begin
            if (accept) perf_br_cnt <= perf_br_cnt + 32'd1;
            if (accept & mis) perf_mis_cnt <= perf_mis_cnt + 32'd1;
        end
    end
`endif
endmodule
